// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter that merges NREQ valid/ready producers onto one FIFO write port.
// Grants are bounded bursts; occupancy tracking keeps the FIFO from ever being written while full.
module fifo_wr_arb #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*WIDTH-1:0]        req_data,
  output logic [NREQ-1:0]              req_ready,
  input  logic [$clog2(DEPTH):0]       fifo_cnt,
  output logic                         fifo_write,
  output logic [WIDTH-1:0]             fifo_data_in,
  output logic [$clog2(NREQ)-1:0]      grant_id,
  output logic                         busy
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned BW = 8;

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [BW-1:0]    bcnt;

  logic [SW-1:0]    need_c;
  logic             space_c;
  logic             found_c;
  logic [IW-1:0]    win_c;
  logic [IW-1:0]    idx_c;
  logic             owner_valid_c;
  logic [WIDTH-1:0] owner_data_c;
  logic             xfer_c;

  // Room for one more word, counting the write already in flight to the FIFO.
  always_comb begin
    need_c  = SW'(fifo_cnt) + SW'(fifo_write) + SW'(1);
    space_c = (need_c <= SW'(DEPTH));
  end

  // First valid requester after the last-served index, wrapping modulo NREQ.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    idx_c   = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx_c = IW'((int'(ptr) + k) % int'(NREQ));
      if (!found_c && req_valid[idx_c]) begin
        found_c = 1'b1;
        win_c   = idx_c;
      end
    end
  end

  always_comb begin
    owner_valid_c = req_valid[grant_id];
    owner_data_c  = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (IW'(i) == grant_id) owner_data_c = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Clear suppresses any handshake in its cycle.
  always_comb begin
    req_ready = '0;
    if (state == OWN && space_c && !clear) req_ready[grant_id] = owner_valid_c;
    xfer_c = (state == OWN) && owner_valid_c && space_c && !clear;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ptr          <= IW'(NREQ - 1);
      bcnt         <= '0;
      fifo_write   <= 1'b0;
      fifo_data_in <= '0;
      grant_id     <= '0;
      busy         <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      ptr        <= IW'(NREQ - 1);
      bcnt       <= '0;
      fifo_write <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          fifo_write <= 1'b0;
          if (found_c && space_c) begin
            state    <= OWN;
            grant_id <= win_c;
            bcnt     <= '0;
            busy     <= 1'b1;
          end
        end
        OWN: begin
          fifo_write <= xfer_c;
          if (xfer_c) begin
            fifo_data_in <= owner_data_c;
            bcnt         <= bcnt + BW'(1);
          end
          // Backpressure alone never releases the grant.
          if (!owner_valid_c || (xfer_c && bcnt == BW'(MAX_BURST - 1))) begin
            state <= IDLE;
            ptr   <= grant_id;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: producer queues, a FIFO occupancy model and a write log.
module tb_fifo_wr_arb;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [4:0]  fifo_cnt;
  logic        fifo_write;
  logic [7:0]  fifo_data_in;
  logic [1:0]  grant_id;
  logic        busy;

  fifo_wr_arb #(.NREQ(4), .WIDTH(8), .DEPTH(DEPTH), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_cnt(fifo_cnt), .fifo_write(fifo_write), .fifo_data_in(fifo_data_in),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  pw [4][32];
  int          head [4];
  int          tail [4];
  logic [7:0]  wd [64];
  logic [1:0]  wg [64];
  int          wn;
  int          tickno;
  logic [31:0] wbits;
  int          cnt;
  logic        drain;
  logic        rd;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input int p, input logic [7:0] v);
    pw[p][tail[p]] = v;
    tail[p]++;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = head[i] < tail[i];
      req_data[i*8 +: 8] = (head[i] < tail[i]) ? pw[i][head[i]] : 8'h00;
    end
  endtask

  // One clock: handshakes and FIFO writes take effect on the edge, producers then update.
  task automatic tick();
    logic [3:0] acc;
    logic       w;
    logic       rdp;
    acc = req_valid & req_ready;
    w   = fifo_write;
    rdp = rd;
    @(posedge clk);
    #1;
    if (w) check("no_overflow", 32'(cnt < DEPTH), 32'd1);
    cnt = cnt + int'(w) - int'(rdp);
    if (drain) cnt = 0;
    fifo_cnt = 5'(cnt);
    for (int i = 0; i < 4; i++) if (acc[i]) head[i]++;
    tickno++;
    if (fifo_write) begin
      if (wn < 64) begin
        wd[wn] = fifo_data_in;
        wg[wn] = grant_id;
      end
      wn++;
      if (tickno <= 32) wbits[tickno-1] = 1'b1;
    end
    drive();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear = 1'b0;
    rd    = 1'b0;
    drain = 1'b0;
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    drive();
    cnt      = 0;
    fifo_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b1;
    wn     = 0;
    tickno = 0;
    wbits  = '0;
  endtask

  initial begin
    reset     = 1'b0;
    clear     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_cnt  = '0;
    rd        = 1'b0;
    drain     = 1'b0;
    cnt       = 0;

    // Single producer, three words
    do_reset();
    check("rst_busy", 32'(busy), 0);
    check("rst_write", 32'(fifo_write), 0);
    check("rst_data", 32'(fifo_data_in), 0);
    check("rst_grant", 32'(grant_id), 0);
    push(0, 8'hA1); push(0, 8'hA2); push(0, 8'hA3);
    drive();
    #1;
    check("idle_ready", 32'(req_ready), 0);
    tick();
    check("t1_ready", 32'(req_ready), 32'h1);
    check("t1_busy", 32'(busy), 1);
    check("t1_write", 32'(fifo_write), 0);
    tick();
    check("t2_write", 32'(fifo_write), 1);
    check("t2_data", 32'(fifo_data_in), 32'hA1);
    tick();
    check("t3_data", 32'(fifo_data_in), 32'hA2);
    tick();
    check("t4_data", 32'(fifo_data_in), 32'hA3);
    check("t4_ready", 32'(req_ready), 0);
    tick();
    check("t5_busy", 32'(busy), 0);
    check("t5_write", 32'(fifo_write), 0);
    check("t5_grant", 32'(grant_id), 0);
    check("single_count", 32'(wn), 3);

    // Full contention: bursts of 4 with one idle cycle between grants
    do_reset();
    drain = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int n = 0; n < 8; n++) push(i, 8'(i*16 + n));
    drive();
    run(25);
    check("cont_pattern", {7'd0, wbits[24:0]}, 32'h01EF7BDE);
    check("cont_count", 32'(wn), 20);
    for (int k = 0; k < 20; k++) begin
      check("cont_data", 32'(wd[k]), 32'(((k/4)%4)*16 + (k/16)*4 + (k%4)));
      check("cont_grant", 32'(wg[k]), 32'((k/4)%4));
    end

    // Backpressure: no reads, FIFO fills to exactly DEPTH
    do_reset();
    for (int n = 0; n < 20; n++) push(0, 8'(n));
    drive();
    run(30);
    check("bp_count", 32'(wn), 16);
    check("bp_cnt", 32'(cnt), 16);
    check("bp_ready", 32'(req_ready), 0);
    check("bp_grant", 32'(grant_id), 0);
    rd = 1'b1;
    tick();
    tick();
    rd = 1'b0;
    run(15);
    check("bp_more", 32'(wn), 18);
    check("bp_cnt2", 32'(cnt), 16);
    check("bp_stall_busy", 32'(busy), 1);
    check("bp_stall_ready", 32'(req_ready), 0);
    check("bp_last", 32'(wd[17]), 32'd17);

    // Skip idle requesters
    do_reset();
    drain = 1'b1;
    push(0, 8'h01);
    drive();
    run(4);
    for (int n = 1; n <= 6; n++) push(1, 8'(8'h10 + n));
    push(3, 8'h31); push(3, 8'h32);
    drive();
    run(20);
    check("skip_count", 32'(wn), 9);
    begin
      logic [7:0] ed [9];
      logic [1:0] eg [9];
      ed = '{8'h01, 8'h11, 8'h12, 8'h13, 8'h14, 8'h31, 8'h32, 8'h15, 8'h16};
      eg = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd1};
      for (int k = 0; k < 9; k++) begin
        check("skip_data", 32'(wd[k]), 32'(ed[k]));
        check("skip_grant", 32'(wg[k]), 32'(eg[k]));
      end
    end

    // Clear during producer 2's second word
    do_reset();
    drain = 1'b1;
    push(1, 8'h51);
    drive();
    run(4);
    push(2, 8'hC1); push(2, 8'hC2); push(2, 8'hC3); push(2, 8'hC4);
    drive();
    tick();
    tick();
    check("clr_first", 32'(fifo_data_in), 32'hC1);
    clear = 1'b1;
    #1;
    check("clr_ready", 32'(req_ready), 0);
    tick();
    check("clr_write", 32'(fifo_write), 0);
    check("clr_busy", 32'(busy), 0);
    clear = 1'b0;
    head[2] = tail[2];
    push(0, 8'h01); push(3, 8'h31);
    drive();
    #1;
    run(10);
    check("clr_count", 32'(wn), 4);
    check("clr_w1", 32'(wd[1]), 32'hC1);
    check("clr_w2", 32'(wd[2]), 32'h01);
    check("clr_w3", 32'(wd[3]), 32'h31);
    check("clr_g2", 32'(wg[2]), 0);

    // Asynchronous reset mid-burst
    do_reset();
    drain = 1'b1;
    push(1, 8'h61); push(1, 8'h62); push(1, 8'h63); push(1, 8'h64);
    drive();
    run(3);
    check("ar_pre_write", 32'(fifo_write), 1);
    #1;
    reset = 1'b0;
    #1;
    check("ar_write", 32'(fifo_write), 0);
    check("ar_data", 32'(fifo_data_in), 0);
    check("ar_grant", 32'(grant_id), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_ready", 32'(req_ready), 0);
    tick();
    check("ar_hold", 32'(wn), 2);
    reset = 1'b1;
    push(0, 8'h01);
    drive();
    #1;
    run(12);
    check("ar_count", 32'(wn), 5);
    check("ar_w2", 32'(wd[2]), 32'h01);
    check("ar_g2", 32'(wg[2]), 0);
    check("ar_w3", 32'(wd[3]), 32'h63);
    check("ar_w4", 32'(wd[4]), 32'h64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write-side arbiter that lets NREQ independent producers share the single write port of the `fifo` block. Each producer offers words over a valid/ready handshake. The arbiter grants one owner at a time for a bounded burst and drives registered `write`/`data_in` into the FIFO. It tracks FIFO occupancy so the FIFO is never written while full, and it sits directly between the producer agents and the FIFO instance.

## Interface
Parameters:
- `NREQ`, 4: number of producers (2..16).
- `WIDTH`, 8: data word width; matches FIFO `WIDTH`.
- `DEPTH`, 16: FIFO depth; matches FIFO `DEPTH`.
- `MAX_BURST`, 4: maximum consecutive transfers per grant (1..255).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserted when 0.
- `clear`  in  1  synchronous soft clear, active-high.
- `req_valid`  in  NREQ  producer i has a word on its data slice.
- `req_data`  in  NREQ*WIDTH  producer i data on bits [i*WIDTH +: WIDTH].
- `req_ready`  out  NREQ  one-hot or zero; transfer on valid&ready.
- `fifo_cnt`  in  $clog2(DEPTH)+1  FIFO `cnt` output.
- `fifo_write`  out  1  to FIFO `write`, registered.
- `fifo_data_in`  out  WIDTH  to FIFO `data_in`, registered.
- `grant_id`  out  $clog2(NREQ)  current or last owner index.
- `busy`  out  1  high while in OWN.

## Operation
- States are IDLE (no owner) and OWN (owner = `grant_id`, burst counter `bcnt`).
- `ptr` is the last-served index. Search order is ptr+1, ptr+2, … modulo NREQ.
- Space: `space = (fifo_cnt + fifo_write + 1) <= DEPTH`, evaluated at full width without overflow. Reads are ignored, which is conservative.
- IDLE:
  - If any `req_valid` is high and `space` holds, the first valid index in search order wins.
  - Next state is OWN with `grant_id` = winner and `bcnt` = 0.
  - `req_ready` is all-zero in IDLE.
- OWN:
  - `req_ready[grant_id] = req_valid[grant_id] & space`, combinational.
  - On transfer, the next edge sets `fifo_write`=1, sets `fifo_data_in` = the owner's slice, and increments `bcnt`.
  - With no transfer, `fifo_write`=0 on the next edge and `fifo_data_in` holds its value.
- OWN to IDLE, with `ptr <= grant_id`, when either:
  - `req_valid[grant_id]` = 0, or
  - the transfer taking `bcnt` to MAX_BURST occurs.
- If the owner is valid but `space` is false, the arbiter stays in OWN and stalls (ready=0). The grant is not released on backpressure.
- `clear` (synchronous, overrides all else):
  - state → IDLE, `ptr` → NREQ-1, `bcnt` → 0, `fifo_write` → 0.
  - Any transfer in that cycle is not accepted (ready forced 0).
- Reset (asynchronous, while `reset`=0) forces:
  - state IDLE, `ptr` = NREQ-1, `bcnt` = 0
  - `fifo_write` = 0, `fifo_data_in` = 0, `grant_id` = 0, `busy` = 0, `req_ready` = 0
- Reset mid-burst drops any pending write. After reset, arbitration starts from index 0.

## Timing
- Arbitration latency: a valid in IDLE at cycle t leads to ready at t+1 (OWN), so data reaches the FIFO with `write` at t+2.
- Steady state: one transfer per cycle within a burst, with no bubbles.
- Every release costs one IDLE cycle: MAX_BURST words per MAX_BURST+1 cycles under full contention.
- `busy`, `grant_id` and `fifo_*` outputs are all registered. `req_ready` is combinational from state, `fifo_cnt`, `fifo_write` and `req_valid`.
- Producers hold valid and data stable until ready. If a producer drops valid without a transfer, its grant ends.
- The FIFO never sees `write`=1 while cnt=DEPTH. With cnt=DEPTH-1 and `fifo_write`=1, ready is 0.

## Test plan
- **Single producer:** req_valid=4'b0001 with 3 words A1..A3 after reset → ready at cycle 2 and writes at cycles 3..5 with data A1,A2,A3. `busy` falls after valid drops; `grant_id`=0.
- **Full contention:** all 4 producers always valid, MAX_BURST=4 → grant order 0,1,2,3,0. Each burst is exactly 4 writes, followed by one idle cycle with no write.
- **Backpressure:** DEPTH=16 with no reads → exactly 16 writes. Ready stays 0 after the 16th accept and `grant_id` is unchanged. Issuing 2 FIFO reads then allows exactly 2 more writes.
- **Skip idle requesters:** ptr=0 with valid=4'b1010 → producer 1 is granted. After its release, producer 3 is granted, then producer 1 again.
- **Clear mid-burst:** `clear` pulses during the 2nd word of producer 2's burst → no write on the following edge. Next arbitration starts at index 0. FIFO receives exactly 1 word from producer 2.
- **Async reset mid-burst:** `reset`=0 between edges → all outputs read 0 immediately, with no extra write. After release, arbitration starts at index 0.
